pi_channel_scheduler: RTL and testbench

//  Time-shares one PI multiply/accumulate datapath between N_CH independent loop channels.

---
 rtl/pi_channel_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_pi_channel_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_channel_scheduler.sv
// -----------------------------------------------------------------------------
// pi_channel_scheduler
//   Time-shares one PI multiply/accumulate datapath between N_CH loop channels.
//   A round-robin arbiter picks one requesting channel. A four-state sequencer
//   then runs the channel through capture, compute and write-back. Each channel
//   has its own integrator. The output is clamped to [OUT_MIN, OUT_MAX], and the
//   clamp error is fed back into the integrator (back-calculation anti-windup).
//
// Ports
//   i_CLK    clock, rising edge
//   i_RST    asynchronous reset, active-low
//   i_req    per-channel request level, held until o_ack
//   i_err    signed 32-bit error per channel, channel k in [32k+31:32k]
//   i_clr    per-channel synchronous integrator clear
//   o_ack    one-hot, one-cycle acknowledge (same cycle as o_valid)
//   o_PI     saturated controller output of the served channel
//   o_ch     channel index that o_PI belongs to
//   o_valid  one-cycle result strobe
//   o_busy   sequencer not idle
// -----------------------------------------------------------------------------
module pi_channel_scheduler #(
    parameter int                 N_CH     = 32'sd4,
    parameter int                 KP       = 32'sd1,
    parameter int                 TsKI     = 32'sd0,
    parameter int                 KAW      = 32'sd0,
    parameter int                 SHIFT_KP = 32'sd0,
    parameter int                 SHIFT_KI = 32'sd0,
    parameter logic signed [31:0] OUT_MAX  = 32'sh7FFF_FFFF,
    parameter logic signed [31:0] OUT_MIN  = 32'sh8000_0000,
    localparam int                CW       = $clog2(N_CH)
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [N_CH-1:0]      i_req,
    input  logic [32*N_CH-1:0]   i_err,
    input  logic [N_CH-1:0]      i_clr,
    output logic [N_CH-1:0]      o_ack,
    output logic signed [31:0]   o_PI,
    output logic [CW-1:0]        o_ch,
    output logic                 o_valid,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_COMPUTE = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    localparam logic signed [63:0]  KP_W     = 64'(KP);
    localparam logic signed [63:0]  KI_W     = 64'(TsKI);
    localparam logic signed [98:0]  KAW_W    = 99'(KAW);
    localparam logic signed [65:0]  OMAX_W   = 66'(OUT_MAX);
    localparam logic signed [65:0]  OMIN_W   = 66'(OUT_MIN);
    localparam logic [N_CH-1:0]     ACK_LSB  = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [CW:0]         N_CH_W   = (CW+1)'(N_CH);

    // Saturate a wide signed value to the signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [99:0] v);
        logic signed [31:0] r;
        if (v > 100'sd2147483647) begin
            r = 32'sh7FFF_FFFF;
        end else if (v < -100'sd2147483648) begin
            r = 32'sh8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    state_t                state_q;
    logic [CW-1:0]         ptr_q;
    logic [CW-1:0]         gnt_q;
    logic signed [31:0]    err_q;
    logic signed [31:0]    i_q;
    logic signed [31:0]    n_q;
    logic signed [63:0]    p_q;
    logic signed [63:0]    q_q;
    logic signed [31:0]    int_q [N_CH];
    logic signed [31:0]    pi_q;
    logic [CW-1:0]         ch_q;
    logic                  valid_q;
    logic [N_CH-1:0]       ack_q;
    logic                  busy_q;

    logic [CW-1:0]         gnt_d;
    logic                  found_s;
    logic [CW:0]           cand_s;
    logic signed [31:0]    err_sel_s;
    logic signed [63:0]    p_d;
    logic signed [63:0]    q_d;
    logic signed [65:0]    u_s;
    logic signed [31:0]    y_s;
    logic signed [66:0]    aw_s;
    logic signed [98:0]    awk_s;
    logic signed [99:0]    n_wide_s;
    logic signed [31:0]    n_d;

    // Round-robin search: first requester after ptr_q, wrapping around.
    always_comb begin
        gnt_d   = ptr_q;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand_s = {1'b0, ptr_q} + (CW+1)'(i);
            if (cand_s >= N_CH_W) begin
                cand_s = cand_s - N_CH_W;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && i_req[cand_s[CW-1:0]]) begin
                gnt_d   = cand_s[CW-1:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Capture-stage products for the granted channel.
    always_comb begin
        err_sel_s = $signed(i_err[{gnt_q, 5'd0} +: 32]);
        p_d       = (64'(err_sel_s) * KP_W) >>> SHIFT_KP;
        q_d       = (64'(int_q[gnt_q]) * KI_W) >>> SHIFT_KI;
    end

    // Compute stage: clamp, anti-windup term and saturated integrator update.
    always_comb begin
        u_s = 66'(p_q) + 66'(q_q);
        if (u_s > OMAX_W) begin
            y_s = OUT_MAX;
        end else if (u_s < OMIN_W) begin
            y_s = OUT_MIN;
        end else begin
            y_s = u_s[31:0];
        end
        aw_s     = 67'(y_s) - 67'(u_s);
        awk_s    = 99'(aw_s) * KAW_W;
        n_wide_s = 100'(i_q) + 100'(err_q) + 100'(awk_s);
        n_d      = sat32(n_wide_s);
    end

    // Sequencer, datapath registers, registered outputs and integrators.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= S_IDLE;
            ptr_q   <= CW'(N_CH - 1);
            gnt_q   <= '0;
            err_q   <= 32'sd0;
            i_q     <= 32'sd0;
            n_q     <= 32'sd0;
            p_q     <= 64'sd0;
            q_q     <= 64'sd0;
            pi_q    <= 32'sd0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                int_q[k] <= 32'sd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    ack_q   <= '0;
                    if (|i_req) begin
                        gnt_q   <= gnt_d;
                        busy_q  <= 1'b1;
                        state_q <= S_CAPTURE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CAPTURE: begin
                    err_q   <= err_sel_s;
                    i_q     <= int_q[gnt_q];
                    p_q     <= p_d;
                    q_q     <= q_d;
                    state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    pi_q    <= y_s;
                    n_q     <= n_d;
                    ch_q    <= gnt_q;
                    valid_q <= 1'b1;
                    ack_q   <= ACK_LSB << gnt_q;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    valid_q <= 1'b0;
                    ack_q   <= '0;
                    ptr_q   <= gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
            // Clear has priority over the write-back of the same channel.
            for (int k = 0; k < N_CH; k++) begin
                if (i_clr[k]) begin
                    int_q[k] <= 32'sd0;
                end else if ((state_q == S_WRITE) && (int'(gnt_q) == k)) begin
                    int_q[k] <= n_q;
                end else begin
                    int_q[k] <= int_q[k];
                end
            end
        end
    end

    assign o_PI    = pi_q;
    assign o_ch    = ch_q;
    assign o_valid = valid_q;
    assign o_ack   = ack_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_pi_channel_scheduler.sv
module tb_pi_channel_scheduler;

    localparam int N    = 4;
    localparam longint KP   = 64'sd2;
    localparam longint KI   = 64'sd1;
    localparam longint KAW  = 64'sd1;
    localparam longint OMAX = 64'sd1000;
    localparam longint OMIN = -64'sd1000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req;
    logic [127:0]       err_bus;
    logic [3:0]         clr;
    logic [3:0]         ack;
    logic signed [31:0] pi;
    logic [1:0]         ch;
    logic               valid;
    logic               busy;

    int errors = 0;
    int checks = 0;

    longint m_int [4];
    longint m_err [4];
    int     m_ptr;
    int     served_q [$];

    pi_channel_scheduler #(
        .N_CH(4), .KP(2), .TsKI(1), .KAW(1), .SHIFT_KP(0), .SHIFT_KI(0),
        .OUT_MAX(32'sd1000), .OUT_MIN(-32'sd1000)
    ) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_req(req), .i_err(err_bus), .i_clr(clr),
        .o_ack(ack), .o_PI(pi), .o_ch(ch), .o_valid(valid), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) m_int[k] = 0;
        m_ptr = N - 1;
    endtask

    // Round-robin choice: first requester after the last served channel.
    function automatic int m_pick(input logic [3:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    // PI law with clamp and back-calculation, evaluated in plain 64-bit arithmetic.
    task automatic m_serve(input int k, output longint y);
        longint e, u, aw, n;
        e  = m_err[k];
        u  = e * KP + m_int[k] * KI;
        y  = (u > OMAX) ? OMAX : ((u < OMIN) ? OMIN : u);
        aw = y - u;
        n  = m_int[k] + e + aw * KAW;
        if (n > 64'sd2147483647) n = 64'sd2147483647;
        else if (n < -64'sd2147483648) n = -64'sd2147483648;
        m_int[k] = n;
        m_ptr    = k;
        served_q.push_back(k);
    endtask

    task automatic drive_err(input int k, input longint v);
        m_err[k] = v;
        err_bus[32*k +: 32] = 32'(v);
    endtask

    task automatic check_ints(input string tag);
        for (int k = 0; k < N; k++) chk($sformatf("%s_int%0d", tag, k), dut.int_q[k], m_int[k]);
    endtask

    // Called at a negedge with the DUT idle; serves every channel in mask.
    task automatic serve_all(input logic [3:0] mask, input logic [3:0] clr_mask);
        logic [3:0] pend;
        int         exp_ch, n;
        bit         first;
        longint     y;
        pend  = mask;
        first = 1'b1;
        req   = pend;
        while (pend != 4'b0000) begin
            exp_ch = m_pick(pend);
            n = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                n++;
                if (valid) break;
            end
            chk("valid_seen", valid, 1);
            chk("latency", n, first ? 3 : 4);
            if (!valid) begin
                pend = 4'b0000;
                req  = pend;
                break;
            end
            m_serve(exp_ch, y);
            chk("ch", ch, exp_ch);
            chk("pi", pi, y);
            chk("ack", ack, 4'b0001 << exp_ch);
            chk("busy", busy, 1);
            if (clr_mask[exp_ch]) begin
                clr[exp_ch]   = 1'b1;
                m_int[exp_ch] = 0;
            end
            pend[exp_ch] = 1'b0;
            req   = pend;
            first = 1'b0;
        end
        @(negedge clk);
        clr = 4'b0000;
        chk("valid_pulse", valid, 0);
        chk("ack_pulse", ack, 0);
    endtask

    initial begin
        int seen;
        longint y;
        rst_n = 1'b0; req = 4'b0000; clr = 4'b0000; err_bus = '0;
        for (int k = 0; k < N; k++) m_err[k] = 0;
        m_reset();
        #2;
        chk("rst_pi", pi, 0);
        chk("rst_ch", ch, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        check_ints("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, twice in a row on channel 0
        drive_err(0, 10);
        serve_all(4'b0001, 4'b0000);
        chk("t1_pi_a", pi, 20);
        serve_all(4'b0001, 4'b0000);
        chk("t1_pi_b", pi, 30);
        check_ints("t1");

        // Arbitration: ch1 last, then everyone requests
        drive_err(1, 5); drive_err(2, -7); drive_err(3, 3);
        serve_all(4'b0010, 4'b0000);
        served_q.delete();
        serve_all(4'b1111, 4'b0000);
        chk("order_len", served_q.size(), 4);
        if (served_q.size() == 4) begin
            chk("order0", served_q[0], 2);
            chk("order1", served_q[1], 3);
            chk("order2", served_q[2], 0);
            chk("order3", served_q[3], 1);
        end
        check_ints("t2");

        // Saturation on channel 2 after clearing its integrator
        clr = 4'b0100; m_int[2] = 0;
        @(negedge clk);
        clr = 4'b0000;
        drive_err(2, 600);
        serve_all(4'b0100, 4'b0000);
        chk("sat_hi", pi, 1000);
        chk("sat_hi_int", dut.int_q[2], 400);
        drive_err(2, -900);
        serve_all(4'b0100, 4'b0000);
        chk("sat_lo", pi, -1000);
        check_ints("t3");

        // Clear colliding with write-back of channel 3
        clr = 4'b1000; m_int[3] = 0;
        @(negedge clk);
        clr = 4'b0000;
        drive_err(3, 50);
        serve_all(4'b1000, 4'b1000);
        chk("clr_pi", pi, 100);
        chk("clr_int3", dut.int_q[3], 0);

        // Full-scale errors need wide arithmetic
        drive_err(0, -64'sd2147483648);
        serve_all(4'b0001, 4'b0000);
        drive_err(0, 64'sd2147483647);
        serve_all(4'b0001, 4'b0000);
        check_ints("edge");

        // Reset while channel 0 is in COMPUTE
        drive_err(0, 77);
        req = 4'b0001;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0; req = 4'b0000;
        m_reset();
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_pi", pi, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk("no_valid_after_rst", seen, 0);
        check_ints("t5");
        served_q.delete();
        serve_all(4'b1111, 4'b0000);
        chk("first_after_rst", (served_q.size() > 0) ? served_q[0] : -1, 0);

        // Channel 1 pulses a request while channel 0 is in service
        drive_err(0, 12); drive_err(1, 999);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("drop_valid", valid, 1);
        m_serve(0, y);
        chk("drop_ch", ch, 0);
        chk("drop_pi", pi, y);
        chk("drop_ack", ack, 4'b0001);
        req = 4'b0000;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[1] || valid) seen++;
        end
        chk("drop_no_ack1", seen, 0);
        check_ints("t6");

        // Random batches against the model
        for (int b = 0; b < 10; b++) begin
            logic [3:0] mask;
            mask = 4'($urandom_range(15, 1));
            for (int k = 0; k < N; k++) drive_err(k, longint'($urandom_range(3000, 0)) - 64'sd1500);
            serve_all(mask, 4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0)));
        end
        check_ints("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
